// File: rtl/data_sram_pkg.sv
// Shared constants and helpers for the data SRAM responder.
// Confreg offsets are the low 16 address bits inside the confreg window.
package data_sram_pkg;

  localparam logic [15:0] LED_OFF    = 16'hf000;
  localparam logic [15:0] NUM_OFF    = 16'hf020;
  localparam logic [15:0] SWITCH_OFF = 16'hf030;
  localparam logic [15:0] TIMER_OFF  = 16'he000;
  localparam logic [15:0] SIMU_OFF   = 16'hffec;

  localparam logic [15:0] LED_RST = 16'hffff;
  localparam logic [31:0] NUM_RST = 32'h0;

  // Replace the bytes of old_val selected by we with the matching bytes of new_val.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  we);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_ram_bank.sv
// Single-port synchronous word RAM with byte enables and a held read register.
// Contents are never reset; only the output register is.
module sram_ram_bank #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (en && (we == 4'b0000)) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// CPU data SRAM slave: local word RAM plus confreg (LED, NUM, switches, timer, sim flag).
// One cycle of read latency; read data holds until the next accepted read.
module data_sram_responder
  import data_sram_pkg::*;
#(
  parameter int          ADDR_W     = 10,
  parameter logic [31:0] CONF_BASE  = 32'hbfaf_0000,
  parameter logic [31:0] TIMER_INIT = 32'h0,
  parameter logic [31:0] SIM_FLAG   = 32'hffff_ffff
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_en,
  input  logic [3:0]  sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  input  logic [7:0]  switch_in,
  output logic [15:0] led_out,
  output logic [31:0] num_data
);

  logic        is_conf;
  logic [15:0] conf_off;
  logic        rd_req;
  logic        wr_req;
  logic        ram_en;
  logic [31:0] ram_rdata;
  logic [31:0] conf_rd;
  logic [31:0] conf_rdata_q;
  logic        sel_conf_q;
  logic [15:0] led;
  logic [31:0] num;
  logic [31:0] timer;
  logic [31:0] led_wr;
  logic [7:0]  sw_meta;
  logic [7:0]  sw_sync;

  assign is_conf  = (sram_addr[31:16] == CONF_BASE[31:16]);
  assign conf_off = sram_addr[15:0];
  assign rd_req   = sram_en && (sram_we == 4'b0000);
  assign wr_req   = sram_en && (sram_we != 4'b0000);
  // Requests seen while reset is high must not reach the (unreset) RAM array.
  assign ram_en   = sram_en && !is_conf && !reset;
  assign led_wr   = byte_merge({16'h0, led}, sram_wdata, sram_we);

  sram_ram_bank #(.ADDR_W(ADDR_W)) u_ram_bank (
    .clk   (clk),
    .reset (reset),
    .en    (ram_en),
    .we    (sram_we),
    .addr  (sram_addr[ADDR_W+1:2]),
    .wdata (sram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    conf_rd = '0;
    case (conf_off)
      LED_OFF:    conf_rd = {16'h0, led};
      NUM_OFF:    conf_rd = num;
      SWITCH_OFF: conf_rd = {24'h0, sw_sync};
      TIMER_OFF:  conf_rd = timer;
      SIMU_OFF:   conf_rd = SIM_FLAG;
      default:    conf_rd = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led          <= LED_RST;
      num          <= NUM_RST;
      timer        <= TIMER_INIT;
      sw_meta      <= '0;
      sw_sync      <= '0;
      conf_rdata_q <= '0;
      sel_conf_q   <= 1'b1;
    end else begin
      sw_meta <= switch_in;
      sw_sync <= sw_meta;
      timer   <= timer + 32'd1;
      if (wr_req && is_conf) begin
        case (conf_off)
          LED_OFF:   led   <= led_wr[15:0];
          NUM_OFF:   num   <= byte_merge(num, sram_wdata, sram_we);
          TIMER_OFF: timer <= byte_merge(timer, sram_wdata, sram_we);
          default:   ;
        endcase
      end
      if (rd_req) begin
        sel_conf_q <= is_conf;
        if (is_conf) conf_rdata_q <= conf_rd;
      end
    end
  end

  assign sram_rdata = sel_conf_q ? conf_rdata_q : ram_rdata;
  assign led_out    = led;
  assign num_data   = num;

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Slave end of the CPU data SRAM interface (en / 4-bit we / addr / wdata in, rdata out). Responds with exactly one cycle of read latency.
- Backs a word-addressed local RAM plus a small confreg region: LED, numeric display, switches, free-running timer and simulation flag.
- Sits beside mycpu_top in the SoC-lite top and replaces the bare data RAM, so test programs can read and write board I/O.

Parameters:
- ADDR_W, 10, RAM word-index width; depth is 2**ADDR_W words.
- CONF_BASE, 32'hbfaf_0000, confreg region base; only bits [31:16] are compared.
- TIMER_INIT, 32'h0, timer reset value.
- SIM_FLAG, 32'hffff_ffff, constant returned at the SIMU_FLAG offset.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- sram_en  in  1  request valid this cycle.
- sram_we  in  4  byte write enables; 4'b0 means read.
- sram_addr  in  32  byte address; bits [1:0] ignored.
- sram_wdata  in  32  write data; byte i is [8i+7:8i].
- sram_rdata  out  32  read data, valid the cycle after the read request.
- switch_in  in  8  asynchronous board switches.
- led_out  out  16  LED register.
- num_data  out  32  numeric display register.

Behaviour:
- Reset (async, immediate):
  - sram_rdata=0, led_out=16'hffff, num_data=0, timer=TIMER_INIT, switch sync flops=0.
  - RAM contents are not reset.
  - A request presented while reset is high is ignored entirely.
- Decode: addr[31:16]==CONF_BASE[31:16] selects conf, otherwise RAM. RAM index is addr[ADDR_W+1:2]; upper bits alias (wrap-around).
- Read (en=1, we=0):
  - sram_rdata is registered at the next posedge.
  - It then holds until the next accepted read; idle cycles and write cycles never change it.
- Write (en=1, we!=0): each we[i] updates byte i at the posedge. No partial-word masking beyond we.
- Back-to-back: a read in cycle N+1 of an address written in cycle N returns the new data.
- en=0: no state change, except timer increment and switch sync.
- Conf offsets (addr[15:0]):
  - 16'hf000 LED: RW. Bytes 0-1 writable; bytes 2-3 read 0, writes ignored.
  - 16'hf020 NUM: RW, 32 bits, byte-enable writes.
  - 16'hf030 SWITCH: RO, returns {24'b0, sw_sync}; writes ignored.
  - 16'he000 TIMER: RW, byte-enable writes.
  - 16'hffec SIMU_FLAG: RO, returns SIM_FLAG.
  - Any other offset: reads 0, writes ignored.
- Timer:
  - Increments by 1 every posedge and wraps 32'hffff_ffff -> 0.
  - A write cycle loads the written bytes and suppresses that cycle's increment; unwritten bytes keep their pre-edge value.
  - A read returns the value held during the request cycle.
  - Write at cycle 0 of value V: timer reads V in cycle 1 and V+n-1 in cycle n.
- Switches: two-flop synchronizer, so switch_in appears in sw_sync after 2 posedges.
- led_out and num_data are driven directly from their registers and update at the write edge.

Decomposition:
- Package data_sram_pkg holds:
  - conf offset constants (LED_OFF, NUM_OFF, SWITCH_OFF, TIMER_OFF, SIMU_OFF);
  - reset constants (LED_RST=16'hffff, NUM_RST=0).
- One sub-module, sram_ram_bank:
  - single-port synchronous RAM, 2**ADDR_W x 32, 4 byte enables;
  - read only when en & ~|we, output register held otherwise.
- Top-level owns decode, conf registers, timer, synchronizer and the rdata mux. The mux selects RAM output or a registered conf read value using the registered region select.

Test Plan:
1. Assert reset mid-cycle during an outstanding read -> sram_rdata=0 and led_out=16'hffff immediately, num_data=0. A request presented while reset is high has no effect after release.
2. Write 32'h12345678 we=4'hf to 0x1c00_0100, read next cycle -> rdata=32'h12345678. Then write 32'haaaabbcc with we=4'b0010 and read -> 32'h1234bb78. Idle cycles after that -> rdata holds.
3. Write 32'hdeadbeef to 0xbfaf_f020 -> num_data=32'hdeadbeef after the edge; read back gives the same. Write 32'h0000_1234 to 0xbfaf_f000 -> led_out=16'h1234; read back gives 32'h0000_1234.
4. Write 32'h100 to 0xbfaf_e000 in cycle 0, read it in cycle 5 -> rdata=32'h104. Load 32'hffff_fffe, read 3 cycles later -> rdata=32'h0 (wrap).
5. Set switch_in=8'h5a, wait 3 cycles, read 0xbfaf_f030 -> 32'h0000005a. Read 0xbfaf_ffec -> SIM_FLAG. Read 0xbfaf_f100 -> 0. Write to 0xbfaf_f030 -> no change.
6. Write 32'h0badf00d to RAM index 0 via 0x1c00_0000, read 0x1c00_0000 + (4<<ADDR_W) -> 32'h0badf00d (alias wrap).
